// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte transmitter (inhibit, frame, ack).
// Optional edge watchdog enabled by defining PS2_TX_TIMEOUT_EN.
`timescale 1ns/1ps
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps_clk,
    input  logic       ps_data,
    output logic       ps_clk_oe,
    output logic       ps_data_oe,
    output logic       tx_done,
    output logic       tx_error
);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        SHIFT,
        ACK,
        WAIT_IDLE,
        DONE
    } state_t;

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);

    state_t        state;
    logic          clk_s1;
    logic          clk_s2;
    logic          clk_prev;
    logic          data_s1;
    logic          data_s2;
    logic          fe;
    logic          wd_hit;
    logic          nack;
    logic [3:0]    idx;
    logic [9:0]    frame;
    logic [IW-1:0] icnt;

    // Synchronizers idle high so reset never fakes a falling edge
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            data_s1  <= 1'b1;
            data_s2  <= 1'b1;
        end else begin
            clk_s1   <= ps_clk;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            data_s1  <= ps_data;
            data_s2  <= data_s1;
        end
    end

    assign fe = clk_prev & ~clk_s2;

`ifdef PS2_TX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] wd;
    logic          watched;

    assign watched = (state == START) || (state == SHIFT) ||
                     (state == ACK) || (state == WAIT_IDLE);

    always_ff @(posedge clk) begin
        if (reset || !watched || fe) begin
            wd <= '0;
        end else begin
            wd <= wd + 1'b1;
        end
    end

    assign wd_hit = watched && !fe && (wd == TO_LAST);
`else
    // No watchdog; the parameter only keeps the interface uniform
    assign wd_hit = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            frame      <= '0;
            idx        <= '0;
            icnt       <= '0;
            nack       <= 1'b0;
            tx_ready   <= 1'b1;
            ps_clk_oe  <= 1'b0;
            ps_data_oe <= 1'b0;
            tx_done    <= 1'b0;
            tx_error   <= 1'b0;
        end else if (wd_hit) begin
            state      <= DONE;
            ps_clk_oe  <= 1'b0;
            ps_data_oe <= 1'b0;
            tx_done    <= 1'b1;
            tx_error   <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (tx_valid && tx_ready) begin
                        // frame = stop, odd parity, D7..D0
                        frame     <= {1'b1, ~^tx_data, tx_data};
                        idx       <= '0;
                        icnt      <= '0;
                        tx_ready  <= 1'b0;
                        ps_clk_oe <= 1'b1;
                        state     <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (icnt == INH_LAST) begin
                        ps_clk_oe  <= 1'b0;
                        ps_data_oe <= 1'b1;
                        state      <= START;
                    end else begin
                        icnt <= icnt + 1'b1;
                    end
                end
                START: begin
                    if (fe) begin
                        ps_data_oe <= ~frame[0];
                        idx        <= 4'd1;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (fe) begin
                        if (idx == 4'd10) begin
                            state <= ACK;
                        end else begin
                            ps_data_oe <= ~frame[idx];
                            idx        <= idx + 1'b1;
                        end
                    end
                end
                ACK: begin
                    if (fe) begin
                        nack  <= data_s2;
                        state <= WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    if (clk_s2 && data_s2) begin
                        tx_done  <= 1'b1;
                        tx_error <= nack;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    tx_done  <= 1'b0;
                    tx_error <= 1'b0;
                    tx_ready <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: device model on open-collector lines plus cycle model.
// Define PS2_TX_TIMEOUT_EN to also exercise the watchdog.
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int INH  = 5000;
    localparam int TO   = 1000;
    localparam int HALF = 40;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       ps_clk_oe;
    logic       ps_data_oe;
    logic       tx_done;
    logic       tx_error;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps_clk_line;
    logic       ps_data_line;

    assign ps_clk_line  = ~(dev_clk_low | ps_clk_oe);
    assign ps_data_line = ~(dev_data_low | ps_data_oe);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ps_clk     (ps_clk_line),
        .ps_data    (ps_data_line),
        .ps_clk_oe  (ps_clk_oe),
        .ps_data_oe (ps_data_oe),
        .tx_done    (tx_done),
        .tx_error   (tx_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    bit run = 1'b0;
    bit m_ready = 1'b1;
    int m_acc = -1;
    int exp_done = -1;
    bit m_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic logic [10:0] frame_of(input logic [7:0] b);
        logic par;
        par = ($countones(b) % 2 == 0);
        return {1'b1, par, b, 1'b0};
    endfunction

    // Transaction model: accept, busy span, expected done cycle
    initial begin
        forever @(posedge clk) begin
            cyc = cyc + 1;
            if (reset) begin
                m_ready = 1'b1;
                m_acc   = -1;
            end else if (!m_ready && exp_done >= 0 && cyc == exp_done + 1) begin
                m_ready = 1'b1;
            end else if (m_ready && tx_valid) begin
                m_ready = 1'b0;
                m_acc   = cyc;
            end
        end
    end

    initial begin : cmp
        int k;
        logic d;
        forever @(negedge clk) begin
            if (run) begin
                chk("ready", 32'(tx_ready), 32'(m_ready));
                d = (cyc == exp_done);
                chk("done", 32'(tx_done), 32'(d));
                if (d) chk("error", 32'(tx_error), 32'(m_err));
                if (m_ready) begin
                    chk("idle_clk_oe", 32'(ps_clk_oe), 32'd0);
                    chk("idle_data_oe", 32'(ps_data_oe), 32'd0);
                end
                if (m_acc >= 0) begin
                    k = cyc - m_acc;
                    if (k >= 0 && k < INH) begin
                        chk("inh_clk_oe", 32'(ps_clk_oe), 32'd1);
                        chk("inh_data_oe", 32'(ps_data_oe), 32'd0);
                    end else if (k == INH) begin
                        chk("start_clk_oe", 32'(ps_clk_oe), 32'd0);
                        chk("start_data_oe", 32'(ps_data_oe), 32'd1);
                    end
                end
            end
        end
    end

    task automatic start_tx(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'hAA;
    endtask

    // Device: clocks n_falls pulses, reads bits on rising edges, acks
    task automatic dev_run(input logic [7:0] b, input bit do_ack,
                           input int n_falls, output logic [10:0] rx);
        logic [10:0] ef;
        logic e;
        bit seen;
        int t;
        ef = frame_of(b);
        rx = '0;
        seen = 1'b0;
        t = 0;
        while (t < INH + 200) begin
            if (!ps_clk_oe && ps_clk_line && !ps_data_line) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            t++;
        end
        chk("start_bit_seen", 32'(seen), 32'd1);
        if (!seen) return;
        repeat (20) @(negedge clk);
        rx[0] = ps_data_line;
        for (int p = 1; p <= n_falls; p++) begin
            dev_clk_low = 1'b1;
            if (p <= 10) begin
                repeat (2) @(negedge clk);
                e = ~ef[p-1];
                chk("oe_before_fe", 32'(ps_data_oe), 32'(e));
                @(negedge clk);
                e = ~ef[p];
                chk("oe_after_fe", 32'(ps_data_oe), 32'(e));
                repeat (HALF - 3) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            if (p == n_falls && p < 12) return;
            if (p <= 10) rx[p] = ps_data_line;
            dev_clk_low = 1'b0;
            if (p == 10) dev_data_low = do_ack;
            if (p == 12) begin
                dev_data_low = 1'b0;
                exp_done = cyc + 3;
                m_err = !do_ack;
                repeat (3) @(negedge clk);
                tx_valid = 1'b0;
                repeat (HALF - 3) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
        end
    endtask

    initial begin : stim
        logic [10:0] rx;
        repeat (2) @(negedge clk);
        run = 1'b1;
        chk("rst_ready", 32'(tx_ready), 32'd1);
        chk("rst_clk_oe", 32'(ps_clk_oe), 32'd0);
        chk("rst_data_oe", 32'(ps_data_oe), 32'd0);
        chk("rst_done", 32'(tx_done), 32'd0);
        chk("rst_error", 32'(tx_error), 32'd0);
        reset = 1'b0;

        // 0xED, accepted at edge 10, tx_valid held until done
        while (cyc < 9) @(negedge clk);
        tx_data  = 8'hED;
        tx_valid = 1'b1;
        while (cyc < 10 + INH - 1) @(negedge clk);
        chk("inh_last_clk_oe", 32'(ps_clk_oe), 32'd1);
        chk("inh_last_data_oe", 32'(ps_data_oe), 32'd0);
        @(negedge clk);
        chk("inh_end_clk_oe", 32'(ps_clk_oe), 32'd0);
        chk("inh_end_data_oe", 32'(ps_data_oe), 32'd1);
        dev_run(8'hED, 1'b1, 12, rx);
        chk("frame_ed", 32'(rx), 32'h7DA);

        // 0x07 with tx_data changed and a stray request while busy
        start_tx(8'h07);
        repeat (100) @(negedge clk);
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        repeat (3) @(negedge clk);
        tx_valid = 1'b0;
        dev_run(8'h07, 1'b1, 12, rx);
        chk("frame_07", 32'(rx), 32'h40E);

        start_tx(8'h00);
        dev_run(8'h00, 1'b1, 12, rx);
        chk("frame_00", 32'(rx), 32'h600);

        // no acknowledge
        start_tx(8'h5A);
        dev_run(8'h5A, 1'b0, 12, rx);
        chk("frame_5a", 32'(rx), 32'h6B4);

        // reset after the 4th device falling edge
        start_tx(8'h3C);
        dev_run(8'h3C, 1'b1, 4, rx);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_ready", 32'(tx_ready), 32'd1);
        chk("midrst_clk_oe", 32'(ps_clk_oe), 32'd0);
        chk("midrst_data_oe", 32'(ps_data_oe), 32'd0);
        chk("midrst_done", 32'(tx_done), 32'd0);
        reset = 1'b0;
        dev_clk_low = 1'b0;
        repeat (20) @(negedge clk);

        start_tx(8'hFF);
        dev_run(8'hFF, 1'b1, 12, rx);
        chk("frame_ff", 32'(rx), 32'h7FE);

`ifdef PS2_TX_TIMEOUT_EN
        // device silent after the start bit
        start_tx(8'h12);
        exp_done = m_acc + INH + TO;
        m_err = 1'b1;
        while (cyc < exp_done + 5) @(negedge clk);
        chk("to_clk_oe", 32'(ps_clk_oe), 32'd0);
        chk("to_data_oe", 32'(ps_data_oe), 32'd0);
`endif

        repeat (10) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got cycle %0d want finish", cyc);
        $fatal(1, "bench stopped by time limit");
    end

endmodule
